// File: rtl/sseg_pkg.sv
// Shared constants for the seven-segment scan driver: active-low segment
// patterns (bit 0 = segment a) for hex digits 0-F and the all-off pattern.
package sseg_pkg;

  localparam logic [0:6] SEG_0 = 7'b0000001;
  localparam logic [0:6] SEG_1 = 7'b1001111;
  localparam logic [0:6] SEG_2 = 7'b0010010;
  localparam logic [0:6] SEG_3 = 7'b0000110;
  localparam logic [0:6] SEG_4 = 7'b1001100;
  localparam logic [0:6] SEG_5 = 7'b0100100;
  localparam logic [0:6] SEG_6 = 7'b0100000;
  localparam logic [0:6] SEG_7 = 7'b0001111;
  localparam logic [0:6] SEG_8 = 7'b0000000;
  localparam logic [0:6] SEG_9 = 7'b0000100;
  localparam logic [0:6] SEG_A = 7'b0001000;
  localparam logic [0:6] SEG_B = 7'b1100000;
  localparam logic [0:6] SEG_C = 7'b0110001;
  localparam logic [0:6] SEG_D = 7'b1000010;
  localparam logic [0:6] SEG_E = 7'b0110000;
  localparam logic [0:6] SEG_F = 7'b0111000;

  localparam logic [0:6] SSEG_OFF = 7'b1111111;

endpackage

// File: rtl/hex_to_sseg.sv
// Combinational nibble to active-low seven-segment decoder.
module hex_to_sseg
  import sseg_pkg::*;
(
  input  logic [3:0] nib_i,
  output logic [0:6] seg_o
);

  always_comb begin
    seg_o = SSEG_OFF;
    case (nib_i)
      4'h0: seg_o = SEG_0;
      4'h1: seg_o = SEG_1;
      4'h2: seg_o = SEG_2;
      4'h3: seg_o = SEG_3;
      4'h4: seg_o = SEG_4;
      4'h5: seg_o = SEG_5;
      4'h6: seg_o = SEG_6;
      4'h7: seg_o = SEG_7;
      4'h8: seg_o = SEG_8;
      4'h9: seg_o = SEG_9;
      4'hA: seg_o = SEG_A;
      4'hB: seg_o = SEG_B;
      4'hC: seg_o = SEG_C;
      4'hD: seg_o = SEG_D;
      4'hE: seg_o = SEG_E;
      4'hF: seg_o = SEG_F;
      default: seg_o = SSEG_OFF;
    endcase
  end

endmodule

// File: rtl/sseg_scan_driver.sv
// Time-multiplexed common-anode seven-segment driver with frame-synchronous
// shadow update, leading-zero blanking, per-digit blink and decimal points.
module sseg_scan_driver
  import sseg_pkg::*;
#(
  parameter int N_DIGITS     = 4,
  parameter int SCAN_DIV     = 50000,
  parameter int GUARD        = 16,
  parameter int BLINK_FRAMES = 128
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [4*N_DIGITS-1:0] value,
  input  logic [N_DIGITS-1:0]   dp,
  input  logic [N_DIGITS-1:0]   blink,
  input  logic                  lz_en,
  input  logic                  upd_req,
  output logic                  upd_ack,
  output logic [0:6]            sseg,
  output logic                  dp_n,
  output logic [N_DIGITS-1:0]   an,
  output logic                  frame_tick
);

  localparam int PC_W  = $clog2(SCAN_DIV);
  localparam int DIG_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam int BC_W  = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  localparam logic [PC_W-1:0]  PC_TC    = PC_W'(SCAN_DIV - 1);
  localparam logic [PC_W-1:0]  PC_GUARD = PC_W'(GUARD);
  localparam logic [DIG_W-1:0] DIG_LAST = DIG_W'(N_DIGITS - 1);
  localparam logic [BC_W-1:0]  BC_LAST  = BC_W'(BLINK_FRAMES - 1);

  logic [PC_W-1:0]       pcnt_q, pcnt_d;
  logic [DIG_W-1:0]      dig_q, dig_d;
  logic [BC_W-1:0]       bcnt_q, bcnt_d;
  logic                  bph_q, bph_d;
  logic [4*N_DIGITS-1:0] val_sh_q, val_sh_d;
  logic [N_DIGITS-1:0]   dp_sh_q, dp_sh_d;
  logic [N_DIGITS-1:0]   an_q, an_d;
  logic [0:6]            sseg_q, sseg_d;
  logic                  dpn_q, dpn_d;
  logic                  ack_q, ack_d;
  logic                  ftick_q, ftick_d;

  logic                  tc, frame_b, lz_blank, blank;
  logic [3:0]            nib;
  logic [0:6]            seg_dec;

  assign tc      = (pcnt_q == PC_TC);
  assign frame_b = tc && (dig_q == DIG_LAST);

  // Scan position, blink phase and shadow capture all advance together so a
  // frame always shows one consistent value and one blink phase.
  always_comb begin
    pcnt_d   = tc ? '0 : pcnt_q + 1'b1;
    dig_d    = dig_q;
    bcnt_d   = bcnt_q;
    bph_d    = bph_q;
    val_sh_d = val_sh_q;
    dp_sh_d  = dp_sh_q;
    if (tc) dig_d = (dig_q == DIG_LAST) ? '0 : dig_q + 1'b1;
    if (frame_b) begin
      if (bcnt_q == BC_LAST) begin
        bcnt_d = '0;
        bph_d  = ~bph_q;
      end else begin
        bcnt_d = bcnt_q + 1'b1;
      end
      if (upd_req) begin
        val_sh_d = value;
        dp_sh_d  = dp;
      end
    end
  end

  assign nib = val_sh_q[4*dig_q +: 4];

  hex_to_sseg u_dec (
    .nib_i (nib),
    .seg_o (seg_dec)
  );

  // A digit is a leading zero when it and every more-significant digit is 0.
  always_comb begin
    lz_blank = lz_en && (dig_q != '0);
    for (int i = 0; i < N_DIGITS; i++) begin
      if ((DIG_W'(i) >= dig_q) && (val_sh_q[4*i +: 4] != 4'h0)) lz_blank = 1'b0;
    end
  end

  assign blank = (pcnt_q < PC_GUARD) || lz_blank || (bph_q && blink[dig_q]);

  always_comb begin
    an_d    = '1;
    sseg_d  = SSEG_OFF;
    dpn_d   = 1'b1;
    if (!blank) begin
      an_d   = ~(N_DIGITS'(1) << dig_q);
      sseg_d = seg_dec;
      dpn_d  = ~dp_sh_q[dig_q];
    end
    ack_d   = frame_b && upd_req;
    ftick_d = frame_b;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pcnt_q   <= '0;
      dig_q    <= '0;
      bcnt_q   <= '0;
      bph_q    <= 1'b0;
      val_sh_q <= '0;
      dp_sh_q  <= '0;
      an_q     <= '1;
      sseg_q   <= SSEG_OFF;
      dpn_q    <= 1'b1;
      ack_q    <= 1'b0;
      ftick_q  <= 1'b0;
    end else begin
      pcnt_q   <= pcnt_d;
      dig_q    <= dig_d;
      bcnt_q   <= bcnt_d;
      bph_q    <= bph_d;
      val_sh_q <= val_sh_d;
      dp_sh_q  <= dp_sh_d;
      an_q     <= an_d;
      sseg_q   <= sseg_d;
      dpn_q    <= dpn_d;
      ack_q    <= ack_d;
      ftick_q  <= ftick_d;
    end
  end

  assign an         = an_q;
  assign sseg       = sseg_q;
  assign dp_n       = dpn_q;
  assign upd_ack    = ack_q;
  assign frame_tick = ftick_q;

endmodule

// File: tb/tb_sseg_scan_driver.sv
// Directed bench for sseg_scan_driver with N_DIGITS=4, SCAN_DIV=8, GUARD=2,
// BLINK_FRAMES=2. Cycle k = k-th rising edge after reset release.
module tb_sseg_scan_driver;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] value = '0;
  logic [3:0]  dp = '0;
  logic [3:0]  blink = '0;
  logic        lz_en = 1'b0;
  logic        upd_req = 1'b0;
  logic        upd_ack;
  logic [0:6]  sseg;
  logic        dp_n;
  logic [3:0]  an;
  logic        frame_tick;

  int cyc = 0;
  int pass_cnt = 0;
  int total_cnt = 0;

  sseg_scan_driver #(
    .N_DIGITS     (4),
    .SCAN_DIV     (8),
    .GUARD        (2),
    .BLINK_FRAMES (2)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .value      (value),
    .dp         (dp),
    .blink      (blink),
    .lz_en      (lz_en),
    .upd_req    (upd_req),
    .upd_ack    (upd_ack),
    .sseg       (sseg),
    .dp_n       (dp_n),
    .an         (an),
    .frame_tick (frame_tick)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic wait_to(input int target);
    while (cyc < target) tick();
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) begin
      pass_cnt++;
    end else begin
      $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Bounded wait for upd_ack; returns the cycle it was seen or -1.
  task automatic wait_ack(output int c);
    c = -1;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (upd_ack === 1'b1) begin
        c = cyc;
        break;
      end
    end
  endtask

  task automatic chk_slot(input string tag, input int k, input logic [3:0] exp_an,
                          input logic [6:0] exp_seg, input logic exp_dpn);
    wait_to(k);
    chk({tag, "_an"}, 32'(an), 32'(exp_an));
    chk({tag, "_seg"}, 32'(sseg), 32'(exp_seg));
    chk({tag, "_dpn"}, 32'(dp_n), 32'(exp_dpn));
  endtask

  initial begin
    int first_an, first_ft, ack_c, bad, lows;

    // Reset held with random inputs
    for (int i = 0; i < 3; i++) begin
      value   = 16'($urandom);
      dp      = 4'($urandom);
      blink   = 4'($urandom);
      lz_en   = 1'($urandom);
      upd_req = 1'($urandom);
      @(posedge clk);
      #1;
      chk("rst_an", 32'(an), 32'hF);
      chk("rst_seg", 32'(sseg), 32'h7F);
      chk("rst_dpn", 32'(dp_n), 32'h1);
      chk("rst_ack", 32'(upd_ack), 32'h0);
      chk("rst_ft", 32'(frame_tick), 32'h0);
    end
    value = '0; dp = '0; blink = '0; lz_en = 1'b0; upd_req = 1'b0;
    rst_n = 1'b1;
    cyc = 0;

    // First lit anode and first frame tick
    first_an = -1;
    first_ft = -1;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (first_an < 0 && an === 4'b1110) first_an = cyc;
      if (first_ft < 0 && frame_tick === 1'b1) first_ft = cyc;
    end
    chk("first_an", 32'(first_an), 32'd3);
    chk("first_ft", 32'(first_ft), 32'd32);

    // Load 12AF; ack at the frame boundary at cycle 64
    value = 16'h12AF;
    upd_req = 1'b1;
    wait_ack(ack_c);
    upd_req = 1'b0;
    chk("ack_12af", 32'(ack_c), 32'd64);
    chk_slot("f2d0", 69, 4'b1110, 7'b0111000, 1'b1);
    chk_slot("f2d1", 77, 4'b1101, 7'b0001000, 1'b1);
    chk_slot("f2d2", 85, 4'b1011, 7'b0010010, 1'b1);
    chk_slot("f2d3", 93, 4'b0111, 7'b1001111, 1'b1);
    wait_to(95);
    chk("ft_95", 32'(frame_tick), 32'h0);
    wait_to(96);
    chk("ft_96", 32'(frame_tick), 32'h1);

    // Leading-zero blanking on 0005
    value = 16'h0005;
    lz_en = 1'b1;
    upd_req = 1'b1;
    wait_ack(ack_c);
    upd_req = 1'b0;
    chk("ack_0005", 32'(ack_c), 32'd128);
    bad = 0;
    lows = 0;
    for (int i = 0; i < 32; i++) begin
      tick();
      if (an !== 4'b1111 && an !== 4'b1110) bad++;
      if (an === 4'b1110) lows++;
      if (cyc == 133) chk("lz_d0_seg", 32'(sseg), 32'(7'b0100100));
    end
    chk("lz_other_an", 32'(bad), 32'd0);
    chk("lz_d0_lit", 32'(lows), 32'd6);
    lz_en = 1'b0;
    chk_slot("nolz_d0", 165, 4'b1110, 7'b0100100, 1'b1);
    chk_slot("nolz_d1", 173, 4'b1101, 7'b0000001, 1'b1);
    chk_slot("nolz_d3", 189, 4'b0111, 7'b0000001, 1'b1);

    // Value change without request is ignored; mid-frame request waits
    wait_to(190);
    value = 16'h3333;
    chk_slot("noupd_d0", 197, 4'b1110, 7'b0100100, 1'b1);
    chk_slot("noupd_d1", 205, 4'b1101, 7'b0000001, 1'b1);
    wait_to(210);
    upd_req = 1'b1;
    wait_ack(ack_c);
    chk("ack_mid", 32'(ack_c), 32'd224);
    chk("old_last_slot", 32'(sseg), 32'(7'b0000001));
    upd_req = 1'b0;
    chk_slot("new_d0", 229, 4'b1110, 7'b0000110, 1'b1);
    chk_slot("new_d3", 253, 4'b0111, 7'b0000110, 1'b1);

    // Blink on digit 1: frames 8,9 lit, 10,11 dark, 12 lit
    wait_to(256);
    blink = 4'b0010;
    chk_slot("bl_f8", 269, 4'b1101, 7'b0000110, 1'b1);
    chk_slot("bl_f9", 301, 4'b1101, 7'b0000110, 1'b1);
    chk_slot("bl_f10d0", 325, 4'b1110, 7'b0000110, 1'b1);
    chk_slot("bl_f10", 333, 4'b1111, 7'b1111111, 1'b1);
    chk_slot("bl_f10d2", 341, 4'b1011, 7'b0000110, 1'b1);
    chk_slot("bl_f11", 365, 4'b1111, 7'b1111111, 1'b1);
    chk_slot("bl_f12", 397, 4'b1101, 7'b0000110, 1'b1);

    // Decimal point on digit 2, then reset mid-slot
    wait_to(416);
    blink = 4'b0000;
    dp = 4'b0100;
    upd_req = 1'b1;
    wait_ack(ack_c);
    upd_req = 1'b0;
    chk("ack_dp", 32'(ack_c), 32'd448);
    chk_slot("dp_d1", 461, 4'b1101, 7'b0000110, 1'b1);
    chk_slot("dp_d2", 469, 4'b1011, 7'b0000110, 1'b0);
    wait_to(470);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_an", 32'(an), 32'hF);
    chk("mid_rst_seg", 32'(sseg), 32'h7F);
    chk("mid_rst_dpn", 32'(dp_n), 32'h1);
    chk("mid_rst_ack", 32'(upd_ack), 32'h0);
    chk("mid_rst_ft", 32'(frame_tick), 32'h0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    cyc = 0;
    chk_slot("post_rst_d0", 3, 4'b1110, 7'b0000001, 1'b1);
    chk_slot("post_rst_d2", 21, 4'b1011, 7'b0000001, 1'b1);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
